lcd_seq: RTL



---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_char_buf.sv | 27 ++
 rtl/lcd_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD command sequencer: FSM states, init command list,
// line-address commands and the refresh item layout.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_PWR_WAIT = 2'd0,
    ST_INIT     = 2'd1,
    ST_IDLE     = 2'd2,
    ST_REFRESH  = 2'd3
  } lcd_state_e;

  localparam logic [8:0] INIT_CMD0 = 9'h038;
  localparam logic [8:0] INIT_CMD1 = 9'h00C;
  localparam logic [8:0] INIT_CMD2 = 9'h001;
  localparam logic [8:0] INIT_CMD3 = 9'h006;

  localparam logic [8:0] LINE0_CMD = 9'h080;
  localparam logic [8:0] LINE1_CMD = 9'h0C0;

  localparam logic [5:0] REFRESH_ITEMS = 6'd34;
  localparam logic [5:0] REFRESH_LAST  = REFRESH_ITEMS - 6'd1;
  localparam logic [5:0] LINE1_IDX     = 6'd17;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  function automatic logic [8:0] init_cmd(input logic [1:0] idx);
    logic [8:0] c;
    case (idx)
      2'd0:    c = INIT_CMD0;
      2'd1:    c = INIT_CMD1;
      2'd2:    c = INIT_CMD2;
      default: c = INIT_CMD3;
    endcase
    return c;
  endfunction

  // Buffer slot carried by a refresh item; meaningless for the two address items.
  function automatic logic [4:0] refresh_slot(input logic [5:0] idx);
    logic [5:0] s;
    s = (idx <= 6'd16) ? (idx - 6'd1) : (idx - 6'd2);
    return s[4:0];
  endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// 32-byte character buffer mirroring the 2x16 display; one write port and one
// combinational read port, reset to blanks.
module lcd_char_buf
  import lcd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic [4:0] i_rd_addr,
  output logic [7:0] o_rd_data
);

  logic [7:0] r_mem [32];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= BLANK_CHAR;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lcd_seq.sv
// HD44780 command sequencer: power-up wait, init list, then repaints the whole
// display from the character buffer whenever the host has written to it.
module lcd_seq
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 2_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic [4:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  output logic [8:0] cmd_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic       init_done_o,
  output logic       busy_o
);

  localparam logic [20:0] WAIT_LAST = 21'(POWERUP_CYCLES - 1);

  lcd_state_e  r_state;
  logic [20:0] r_wait;
  logic [1:0]  r_init_idx;
  logic [5:0]  r_ref_idx;
  logic        r_dirty;
  logic [8:0]  r_cmd;
  logic        r_cmd_valid;
  logic        r_init_done;

  logic        w_xfer;
  logic [5:0]  w_load_idx;
  logic [4:0]  w_rd_addr;
  logic [7:0]  w_rd_data;
  logic [8:0]  w_ref_item;

  lcd_char_buf u_buf (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_wr_en   (wr_en_i),
    .i_wr_addr (wr_addr_i),
    .i_wr_data (wr_data_i),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign w_xfer = r_cmd_valid & cmd_ready_i;

  // With nothing latched the current index is loaded; otherwise the one after it.
  assign w_load_idx = r_cmd_valid ? (r_ref_idx + 6'd1) : r_ref_idx;
  assign w_rd_addr  = refresh_slot(w_load_idx);

  always_comb begin
    w_ref_item = {1'b1, w_rd_data};
    if (w_load_idx == 6'd0)           w_ref_item = LINE0_CMD;
    else if (w_load_idx == LINE1_IDX) w_ref_item = LINE1_CMD;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_PWR_WAIT;
      r_wait      <= '0;
      r_init_idx  <= '0;
      r_ref_idx   <= '0;
      r_dirty     <= 1'b1;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_PWR_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_state     <= ST_INIT;
            r_init_idx  <= 2'd0;
            r_cmd       <= init_cmd(2'd0);
            r_cmd_valid <= 1'b1;
          end else begin
            r_wait <= r_wait + 21'd1;
          end
        end
        ST_INIT: begin
          if (w_xfer) begin
            if (r_init_idx == 2'd3) begin
              r_cmd_valid <= 1'b0;
              r_init_done <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_init_idx <= r_init_idx + 2'd1;
              r_cmd      <= init_cmd(r_init_idx + 2'd1);
            end
          end
        end
        ST_IDLE: begin
          if (r_dirty) begin
            r_dirty   <= 1'b0;
            r_ref_idx <= 6'd0;
            r_state   <= ST_REFRESH;
          end
        end
        default: begin
          if (!r_cmd_valid) begin
            r_cmd       <= w_ref_item;
            r_cmd_valid <= 1'b1;
          end else if (w_xfer) begin
            if (r_ref_idx == REFRESH_LAST) begin
              r_cmd_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_ref_idx <= w_load_idx;
              r_cmd     <= w_ref_item;
            end
          end
        end
      endcase
      // A host write overrides the clear taken in IDLE on the same cycle.
      if (wr_en_i) r_dirty <= 1'b1;
    end
  end

  assign cmd_o       = r_cmd;
  assign cmd_valid_o = r_cmd_valid;
  assign init_done_o = r_init_done;
  assign busy_o      = (r_state != ST_IDLE);

endmodule
